// File: rtl/cmd_scheduler_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cmd_scheduler_if : operation handshake between cmd_scheduler and game_control
// Revision 1.0
// -----------------------------------------------------------------------------
interface cmd_scheduler_if;
  logic       op_valid;
  logic [2:0] op_code;
  logic       op_ready;
  logic       op_done;

  modport master (
    output op_valid,
    output op_code,
    input  op_ready,
    input  op_done
  );

  modport slave (
    input  op_valid,
    input  op_code,
    output op_ready,
    output op_done
  );
endinterface
`default_nettype wire

// File: rtl/cmd_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cmd_scheduler : latches, arbitrates and issues piece operations to the engine
// Revision 1.0
// -----------------------------------------------------------------------------
module cmd_scheduler #(
  parameter int GRAVITY_BASE = 48,
  parameter int GRAVITY_STEP = 4,
  parameter int GRAVITY_MIN  = 2,
  parameter int LOCK_TICKS   = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_game,
  input  logic                   cmd_left,
  input  logic                   cmd_right,
  input  logic                   cmd_down,
  input  logic                   cmd_rotate,
  input  logic                   cmd_drop,
  input  logic                   cmd_hold,
  input  logic [3:0]             level,
  input  logic                   grounded,
  input  logic                   game_over,
  cmd_scheduler_if.master        bus,
  output logic                   sched_busy
);

  localparam logic [2:0] OP_HOLD    = 3'd0;
  localparam logic [2:0] OP_DROP    = 3'd1;
  localparam logic [2:0] OP_ROTATE  = 3'd2;
  localparam logic [2:0] OP_LEFT    = 3'd3;
  localparam logic [2:0] OP_RIGHT   = 3'd4;
  localparam logic [2:0] OP_DOWN    = 3'd5;
  localparam logic [2:0] OP_GRAVITY = 3'd6;
  localparam logic [2:0] OP_LOCK    = 3'd7;

  localparam logic signed [8:0] GRAV_MIN_S = 9'(GRAVITY_MIN);
  localparam logic [5:0]        LOCK_MAX   = 6'(LOCK_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e     state_q;
  logic       op_valid_q;
  logic [2:0] op_code_q;
  logic       busy_q;
  logic [7:0] pend_q,     pend_d;
  logic [7:0] grav_cnt_q, grav_cnt_d;
  logic [5:0] lock_cnt_q, lock_cnt_d;

  logic              accept;
  logic              flush;
  logic              down_acc;
  logic              grav_req;
  logic              lock_req;
  logic [7:0]        req;
  logic [2:0]        sel_code;
  logic signed [8:0] grav_raw;
  logic signed [8:0] grav_interval;
  logic [8:0]        grav_next;

  assign accept   = op_valid_q & bus.op_ready;
  assign flush    = accept & ((op_code_q == OP_HOLD) | (op_code_q == OP_DROP) |
                              (op_code_q == OP_LOCK));
  assign down_acc = accept & (op_code_q == OP_DOWN);

  // Signed so that high levels go negative and are caught by the clamp.
  assign grav_raw      = $signed(9'(GRAVITY_BASE)) - $signed(9'(GRAVITY_STEP) * {5'd0, level});
  assign grav_interval = (grav_raw < GRAV_MIN_S) ? GRAV_MIN_S : grav_raw;
  assign grav_next     = {1'b0, grav_cnt_q} + 9'd1;

  always_comb begin
    grav_cnt_d = grav_cnt_q;
    grav_req   = 1'b0;
    if (game_over | flush | down_acc) begin
      grav_cnt_d = 8'd0;
    end else if (tick_game & ~grounded) begin
      if (grav_next >= $unsigned(grav_interval)) begin
        grav_cnt_d = 8'd0;
        grav_req   = 1'b1;
      end else begin
        grav_cnt_d = grav_next[7:0];
      end
    end
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    lock_req   = 1'b0;
    if (game_over | flush | ~grounded) begin
      lock_cnt_d = 6'd0;
    end else if (tick_game && (lock_cnt_q != LOCK_MAX)) begin
      lock_cnt_d = lock_cnt_q + 6'd1;
      lock_req   = ((lock_cnt_q + 6'd1) == LOCK_MAX);
    end
  end

  always_comb begin
    req             = 8'd0;
    req[OP_HOLD]    = cmd_hold;
    req[OP_DROP]    = cmd_drop;
    req[OP_ROTATE]  = cmd_rotate;
    req[OP_LEFT]    = cmd_left;
    req[OP_RIGHT]   = cmd_right;
    req[OP_DOWN]    = cmd_down;
    req[OP_GRAVITY] = grav_req;
    req[OP_LOCK]    = lock_req;
  end

  // Clears are applied first so a same-cycle request wins; a flush also
  // swallows every request arriving with it.
  always_comb begin
    pend_d = pend_q;
    if (accept) begin
      pend_d[op_code_q] = 1'b0;
    end
    if (down_acc) begin
      pend_d[OP_GRAVITY] = 1'b0;
    end
    if (flush) begin
      pend_d = pend_d & 8'b0000_0011;
    end else begin
      pend_d = pend_d | req;
    end
    if (game_over) begin
      pend_d = 8'd0;
    end
  end

  always_comb begin
    sel_code = OP_GRAVITY;
    if      (pend_q[OP_HOLD])   sel_code = OP_HOLD;
    else if (pend_q[OP_DROP])   sel_code = OP_DROP;
    else if (pend_q[OP_LOCK])   sel_code = OP_LOCK;
    else if (pend_q[OP_ROTATE]) sel_code = OP_ROTATE;
    else if (pend_q[OP_LEFT])   sel_code = OP_LEFT;
    else if (pend_q[OP_RIGHT])  sel_code = OP_RIGHT;
    else if (pend_q[OP_DOWN])   sel_code = OP_DOWN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_valid_q <= 1'b0;
      op_code_q  <= 3'd0;
      busy_q     <= 1'b0;
      pend_q     <= 8'd0;
      grav_cnt_q <= 8'd0;
      lock_cnt_q <= 6'd0;
    end else begin
      pend_q     <= pend_d;
      grav_cnt_q <= grav_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if ((|pend_q) && !game_over) begin
            state_q    <= ST_ISSUE;
            op_valid_q <= 1'b1;
            op_code_q  <= sel_code;
            busy_q     <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (bus.op_ready) begin
            state_q    <= ST_WAIT;
            op_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.op_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          op_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_valid = op_valid_q;
  assign bus.op_code  = op_code_q;
  assign sched_busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cmd_scheduler : scoreboard bench for cmd_scheduler
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_cmd_scheduler;

  localparam int TICK_GAP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_game = 1'b0;
  logic       cmd_left = 1'b0, cmd_right = 1'b0, cmd_down = 1'b0;
  logic       cmd_rotate = 1'b0, cmd_drop = 1'b0, cmd_hold = 1'b0;
  logic [3:0] level = 4'd0;
  logic       grounded = 1'b0;
  logic       game_over = 1'b0;
  logic       sched_busy;

  cmd_scheduler_if bus();

  cmd_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_game  (tick_game),
    .cmd_left   (cmd_left),
    .cmd_right  (cmd_right),
    .cmd_down   (cmd_down),
    .cmd_rotate (cmd_rotate),
    .cmd_drop   (cmd_drop),
    .cmd_hold   (cmd_hold),
    .level      (level),
    .grounded   (grounded),
    .game_over  (game_over),
    .bus        (bus),
    .sched_busy (sched_busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] sb[$];
  int         acc_cnt = 0;
  int         tick_no = 0;
  int         last_grav_tick = 0;
  int         prev_grav_tick = 0;
  int         last_lock_tick = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Engine model: pops the scoreboard on each acceptance and pulses op_done
  // in the fourth cycle after the accepting cycle.
  initial begin
    logic [2:0] exp_code;
    bus.op_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.op_valid && bus.op_ready) begin
        acc_cnt++;
        if (sb.size() == 0) begin
          check("sb_unexpected_op", sb.size(), 1);
        end else begin
          exp_code = sb.pop_front();
          check("op_code", int'(bus.op_code), int'(exp_code));
        end
        if (bus.op_code == 3'd6) begin
          prev_grav_tick = last_grav_tick;
          last_grav_tick = tick_no;
        end
        if (bus.op_code == 3'd7) last_lock_tick = tick_no;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 bus.op_done = 1'b1;
        @(posedge clk);
        #1 bus.op_done = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    {cmd_hold, cmd_drop, cmd_rotate, cmd_left, cmd_right, cmd_down} = 6'd0;
    tick_game = 1'b0; game_over = 1'b0; grounded = 1'b0; level = 4'd0;
    bus.op_ready = 1'b1;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mask = {hold, drop, rotate, left, right, down}
  task automatic pulse(input logic [5:0] mask);
    @(posedge clk);
    #1 {cmd_hold, cmd_drop, cmd_rotate, cmd_left, cmd_right, cmd_down} = mask;
    @(posedge clk);
    #1 {cmd_hold, cmd_drop, cmd_rotate, cmd_left, cmd_right, cmd_down} = 6'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1 tick_game = 1'b1;
    tick_no++;
    @(posedge clk);
    #1 tick_game = 1'b0;
    repeat (TICK_GAP - 2) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget, input string tag);
    int b = 0;
    while (acc_cnt < target && b < budget) begin
      @(posedge clk);
      b++;
    end
    if (acc_cnt < target) check(tag, acc_cnt, target);
    #1;
  endtask

  task automatic wait_quiet(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic grav_run(input logic [3:0] lvl, input int interval, input int nticks,
                          input string tag);
    int base;
    int t0;
    do_reset();
    level = lvl;
    base  = acc_cnt;
    t0    = tick_no;
    for (int i = 1; i <= nticks; i++) begin
      if (i % interval == 0) sb.push_back(3'd6);
      tick();
    end
    wait_quiet(20);
    check({tag, "_count"}, acc_cnt - base, nticks / interval);
    check({tag, "_last"}, last_grav_tick - t0, (nticks / interval) * interval);
    check({tag, "_interval"}, last_grav_tick - prev_grav_tick, interval);
    check({tag, "_drain"}, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t1;
    int gap;
    int bad;
    int hi;
    bus.op_ready = 1'b1;
    #12;
    check("rst_op_valid", int'(bus.op_valid), 0);
    check("rst_op_code", int'(bus.op_code), 0);
    check("rst_busy", int'(sched_busy), 0);

    // Gravity intervals, including the clamp at level 12 and negative raw at 15
    grav_run(4'd0,  48, 96, "grav_l0");
    grav_run(4'd10,  8, 24, "grav_l10");
    grav_run(4'd12,  2,  8, "grav_l12");
    grav_run(4'd15,  2,  6, "grav_l15");

    // HOLD flushes the co-pending LEFT and ROTATE
    do_reset();
    base = acc_cnt;
    sb.push_back(3'd0);
    pulse(6'b101100);
    wait_acc(base + 1, 50, "hold_timeout");
    wait_quiet(30);
    check("hold_only_count", acc_cnt - base, 1);
    check("hold_drain", sb.size(), 0);

    // LEFT then RIGHT, with the idle gap between them
    do_reset();
    base = acc_cnt;
    sb.push_back(3'd3);
    sb.push_back(3'd4);
    pulse(6'b000110);
    wait_acc(base + 1, 50, "lr_first_timeout");
    gap = 0;
    @(negedge clk);
    while (!bus.op_valid && gap < 50) begin
      gap++;
      @(negedge clk);
    end
    check("lr_gap", gap, 5);
    wait_acc(base + 2, 50, "lr_second_timeout");
    wait_quiet(30);
    check("lr_count", acc_cnt - base, 2);

    // Lock delay: nothing after 29 grounded ticks, LOCK on the 30th
    do_reset();
    grounded = 1'b1;
    base = acc_cnt;
    t1 = tick_no;
    repeat (29) tick();
    check("lock_29_none", acc_cnt - base, 0);
    sb.push_back(3'd7);
    tick();
    wait_acc(base + 1, 50, "lock_timeout");
    check("lock_at_30", last_lock_tick - t1, 30);

    // Leaving the ground at tick 29 restarts the lock count
    do_reset();
    grounded = 1'b1;
    base = acc_cnt;
    repeat (29) tick();
    grounded = 1'b0;
    wait_quiet(3);
    grounded = 1'b1;
    t1 = tick_no;
    repeat (29) tick();
    check("lock_restart_none", acc_cnt - base, 0);
    sb.push_back(3'd7);
    tick();
    wait_acc(base + 1, 50, "lock_restart_timeout");
    check("lock_restart_at_30", last_lock_tick - t1, 30);

    // Stalled engine: op_code stable, repeated DOWN pulses coalesce
    do_reset();
    bus.op_ready = 1'b0;
    base = acc_cnt;
    sb.push_back(3'd5);
    pulse(6'b000001);
    bad = 0;
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      cmd_down = (c == 5 || c == 11);
      @(negedge clk);
      if (bus.op_valid) begin
        hi++;
        if (bus.op_code != 3'd5) bad++;
      end
      @(posedge clk);
      #1;
    end
    cmd_down = 1'b0;
    check("down_stable", bad, 0);
    check("down_valid_cycles", hi, 19);
    check("down_busy_issue", int'(sched_busy), 1);
    bus.op_ready = 1'b1;
    wait_acc(base + 1, 50, "down_timeout");
    wait_quiet(30);
    check("down_count", acc_cnt - base, 1);

    // game_over during WAIT: op completes, nothing new, counters held at 0
    do_reset();
    level = 4'd10;
    base = acc_cnt;
    sb.push_back(3'd2);
    pulse(6'b001000);
    wait_acc(base + 1, 50, "go_timeout");
    game_over = 1'b1;
    check("go_busy_in_wait", int'(sched_busy), 1);
    pulse(6'b000100);
    grounded = 1'b1;
    repeat (6) tick();
    check("go_lock_cnt", int'(dut.lock_cnt_q), 0);
    grounded = 1'b0;
    repeat (12) tick();
    wait_quiet(10);
    check("go_no_issue", acc_cnt - base, 1);
    check("go_idle", int'(sched_busy), 0);
    check("go_grav_cnt", int'(dut.grav_cnt_q), 0);
    game_over = 1'b0;
    t1 = tick_no;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) sb.push_back(3'd6);
      tick();
    end
    wait_acc(base + 2, 50, "go_grav_timeout");
    check("go_grav_restart", last_grav_tick - t1, 8);

    // Asynchronous reset in the middle of ISSUE
    do_reset();
    bus.op_ready = 1'b0;
    base = acc_cnt;
    pulse(6'b100000);
    gap = 0;
    @(negedge clk);
    while (!bus.op_valid && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    check("rst_mid_pre_valid", int'(bus.op_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", int'(bus.op_valid), 0);
    check("rst_mid_busy", int'(sched_busy), 0);
    check("rst_mid_code", int'(bus.op_code), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.op_ready = 1'b1;
    wait_quiet(20);
    check("rst_mid_no_issue", acc_cnt - base, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
